// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: shadow of in-flight destinations across the forwarding
// stages plus a busy-bit scoreboard for long-latency results.
module hazard_scoreboard #(
    parameter int NREAD      = 2,
    parameter int NSTAGES    = 2,
    parameter int LOAD_READY = 2,
    parameter int SELW       = $clog2(NSTAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  de_valid,
    input  logic [NREAD*5-1:0]    de_rs,
    input  logic [4:0]            de_rd,
    input  logic                  de_we,
    input  logic [1:0]            de_class,
    input  logic                  pipe_adv,
    input  logic                  flush,
    input  logic                  lx_done,
    input  logic [4:0]            lx_rd,
    output logic                  stall,
    output logic [NREAD*SELW-1:0] fwd_sel,
    output logic [31:0]           busy
);

    localparam logic [1:0] CLASS_LOAD = 2'd1;
    localparam logic [1:0] CLASS_LONG = 2'd2;

    // Shadow entry k holds the destination of the instruction now in stage k.
    logic            v_q   [1:NSTAGES];
    logic [4:0]      rd_q  [1:NSTAGES];
    logic [SELW-1:0] rdy_q [1:NSTAGES];
    logic            v_d   [1:NSTAGES];
    logic [4:0]      rd_d  [1:NSTAGES];
    logic [SELW-1:0] rdy_d [1:NSTAGES];

    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [NREAD-1:0] port_stall;
    logic             waw_stall;
    logic             issue;
    logic             ins_shadow;
    logic             set_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_port
            logic [4:0]      rs;
            logic [SELW-1:0] sel;
            logic            not_ready;
            logic            rs_busy;

            assign rs = de_rs[5*gi +: 5];

            // Scan oldest to youngest so the youngest matching stage overrides.
            always_comb begin
                sel       = '0;
                not_ready = 1'b0;
                if (rs != 5'd0) begin
                    for (int k = NSTAGES; k >= 1; k--) begin
                        if (v_q[k] && (rd_q[k] == rs)) begin
                            sel       = SELW'(k);
                            not_ready = (rdy_q[k] > SELW'(k));
                        end
                    end
                end
            end

            assign rs_busy                    = (rs != 5'd0) && busy_q[rs];
            assign port_stall[gi]             = not_ready | rs_busy;
            assign fwd_sel[SELW*gi +: SELW]   = de_valid ? sel : '0;
        end
    endgenerate

    // WAW guard also keeps a busy set and clear from hitting the same register.
    assign waw_stall  = de_we && (de_rd != 5'd0) && busy_q[de_rd];
    assign stall      = de_valid && ((|port_stall) || waw_stall);
    assign issue      = de_valid && !stall && pipe_adv;
    assign ins_shadow = issue && de_we && (de_rd != 5'd0) && (de_class != CLASS_LONG);
    assign set_busy   = issue && de_we && (de_rd != 5'd0) && (de_class == CLASS_LONG);
    assign busy       = busy_q;

    always_comb begin
        for (int k = 1; k <= NSTAGES; k++) begin
            v_d[k]   = v_q[k];
            rd_d[k]  = rd_q[k];
            rdy_d[k] = rdy_q[k];
        end
        if (flush) begin
            for (int k = 1; k <= NSTAGES; k++) begin
                v_d[k] = 1'b0;
            end
        end else if (pipe_adv) begin
            for (int k = NSTAGES; k >= 2; k--) begin
                v_d[k]   = v_q[k-1];
                rd_d[k]  = rd_q[k-1];
                rdy_d[k] = rdy_q[k-1];
            end
            v_d[1]   = ins_shadow;
            rd_d[1]  = de_rd;
            rdy_d[1] = (de_class == CLASS_LOAD) ? SELW'(LOAD_READY) : SELW'(1);
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (lx_done) begin
            busy_d[lx_rd] = 1'b0;
        end
        if (set_busy) begin
            busy_d[de_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGES; k++) begin
                v_q[k]   <= 1'b0;
                rd_q[k]  <= 5'd0;
                rdy_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 1; k <= NSTAGES; k++) begin
                v_q[k]   <= v_d[k];
                rd_q[k]  <= rd_d[k];
                rdy_q[k] <= rdy_d[k];
            end
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios followed by
// random traffic, all compared against an age-based model of in-flight instructions.
module tb_hazard_scoreboard;

    localparam int NREAD      = 2;
    localparam int NSTAGES    = 2;
    localparam int LOAD_READY = 2;
    localparam int SELW       = $clog2(NSTAGES + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  de_valid;
    logic [NREAD*5-1:0]    de_rs;
    logic [4:0]            de_rd;
    logic                  de_we;
    logic [1:0]            de_class;
    logic                  pipe_adv;
    logic                  flush;
    logic                  lx_done;
    logic [4:0]            lx_rd;
    logic                  stall;
    logic [NREAD*SELW-1:0] fwd_sel;
    logic [31:0]           busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREAD(NREAD), .NSTAGES(NSTAGES), .LOAD_READY(LOAD_READY), .SELW(SELW)
    ) dut (
        .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs(de_rs), .de_rd(de_rd),
        .de_we(de_we), .de_class(de_class), .pipe_adv(pipe_adv), .flush(flush),
        .lx_done(lx_done), .lx_rd(lx_rd), .stall(stall), .fwd_sel(fwd_sel), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    // Model: each issued writer remembers the advance count at which it entered;
    // its stage is simply how many advances have happened since.
    typedef struct {
        logic [4:0] rd;
        bit         ld;
        int         a0;
    } rec_t;
    rec_t                  q[$];
    int                    adv_cnt = 0;
    logic [31:0]           m_busy = '0;
    bit                    exp_stall;
    logic [NREAD*SELW-1:0] exp_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit st;
        st      = 1'b0;
        exp_sel = '0;
        for (int i = 0; i < NREAD; i++) begin
            logic [4:0] rs;
            int         best;
            bit         bld;
            rs   = de_rs[5*i +: 5];
            best = 0;
            bld  = 1'b0;
            if (rs != 5'd0) begin
                foreach (q[j]) begin
                    int s;
                    s = adv_cnt - q[j].a0;
                    if (s >= 1 && s <= NSTAGES && q[j].rd == rs && (best == 0 || s < best)) begin
                        best = s;
                        bld  = q[j].ld;
                    end
                end
                if (bld && LOAD_READY > best) st = 1'b1;
                if (m_busy[rs]) st = 1'b1;
            end
            exp_sel[SELW*i +: SELW] = de_valid ? SELW'(best) : '0;
        end
        if (de_we && de_rd != 5'd0 && m_busy[de_rd]) st = 1'b1;
        exp_stall = de_valid && st;
    endtask

    task automatic drive(input bit v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input bit we, input logic [1:0] cls,
                         input bit adv, input bit fl, input bit lxd, input logic [4:0] lxr,
                         input bit rst);
        reset    = rst;
        de_valid = v;
        de_rs    = {rs1, rs0};
        de_rd    = rd;
        de_we    = we;
        de_class = cls;
        pipe_adv = adv;
        flush    = fl;
        lx_done  = lxd;
        lx_rd    = lxr;
        #1;
        model_eval();
        check("stall", {31'b0, stall}, {31'b0, exp_stall});
        check("fwd_sel", 32'(fwd_sel), 32'(exp_sel));
        check("busy", busy, m_busy);
    endtask

    task automatic tick();
        bit iss;
        iss = de_valid && !exp_stall && pipe_adv;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_busy = '0;
        end else begin
            if (lx_done) m_busy[lx_rd] = 1'b0;
            if (iss && de_class == 2'd2 && de_we && de_rd != 5'd0) m_busy[de_rd] = 1'b1;
            if (flush) begin
                q.delete();
            end else if (pipe_adv) begin
                adv_cnt++;
                if (iss && de_we && de_rd != 5'd0 && de_class != 2'd2)
                    q.push_back('{de_rd, de_class == 2'd1, adv_cnt - 1});
                while (q.size() > 0 && adv_cnt - q[0].a0 > NSTAGES) void'(q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; de_valid = 1'b0; de_rs = '0; de_rd = '0; de_we = 1'b0;
        de_class = '0; pipe_adv = 1'b0; flush = 1'b0; lx_done = 1'b0; lx_rd = '0;
        exp_stall = 1'b0;
        @(negedge clk);
        tick();

        // Reset state
        drive(0, 5, 6, 5, 1, 0, 1, 0, 0, 0, 0);
        check("reset_busy", busy, 32'h0);
        check("reset_sel", 32'(fwd_sel), 32'h0);
        tick();

        // Back-to-back ALU
        drive(1, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("alu_sel1", 32'(fwd_sel[SELW-1:0]), 1);
        check("alu_stall", {31'b0, stall}, 0);
        tick();
        drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("alu_sel2", 32'(fwd_sel[SELW-1:0]), 2);
        tick();
        drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("alu_sel0", 32'(fwd_sel[SELW-1:0]), 0);
        tick();

        // Load-use
        drive(1, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0);
        check("ld_stall", {31'b0, stall}, 1);
        check("ld_sel1", 32'(fwd_sel[2*SELW-1:SELW]), 1);
        tick();
        drive(1, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0);
        check("ld_nostall", {31'b0, stall}, 0);
        check("ld_sel2", 32'(fwd_sel[2*SELW-1:SELW]), 2);
        tick();

        // Youngest wins
        drive(1, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("young_sel", 32'(fwd_sel[SELW-1:0]), 1);
        tick();

        // Long latency, then hold and flush while the divide is still pending
        drive(1, 0, 0, 9, 1, 2, 1, 0, 0, 0, 0); tick();
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("div_busy", {31'b0, busy[9]}, 1);
        check("div_rd_stall", {31'b0, stall}, 1);
        tick();
        drive(1, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0);
        check("div_waw_stall", {31'b0, stall}, 1);
        tick();
        drive(1, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("hold_sel", 32'(fwd_sel[SELW-1:0]), 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_sel", 32'(fwd_sel[SELW-1:0]), 0);
        check("flush_busy", {31'b0, busy[9]}, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
        drive(1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("lx_busy", {31'b0, busy[9]}, 0);
        check("lx_stall", {31'b0, stall}, 0);
        check("lx_sel", 32'(fwd_sel[SELW-1:0]), 0);
        tick();

        // Reset with state populated, then x0 handling
        drive(1, 0, 0, 10, 1, 2, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 11, 1, 0, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1); tick();
        drive(1, 11, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_busy", busy, 32'h0);
        check("rst_sel", 32'(fwd_sel), 32'h0);
        tick();
        drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("x0_sel", 32'(fwd_sel), 32'h0);
        check("x0_stall", {31'b0, stall}, 0);
        tick();

        // Random traffic over a small register set so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            bit         v, we, adv, fl, lxd, rst;
            logic [4:0] rs0, rs1, rd, lxr;
            logic [1:0] cls;
            v   = ($urandom_range(0, 3) != 0);
            rs0 = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            we  = ($urandom_range(0, 4) != 0);
            cls = 2'($urandom_range(0, 3));
            adv = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            if (fl) v = 1'b0;
            rst = ($urandom_range(0, 99) == 0);
            lxd = ($urandom_range(0, 2) == 0);
            lxr = 5'($urandom_range(0, 7));
            if (lxd && !m_busy[lxr] && lxr == rd) lxd = 1'b0;
            drive(v, rs0, rs1, rd, we, cls, adv, fl, lxd, lxr, rst);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
